// File: rtl/hamming_secded_stream_decoder.sv
// Pipelined Hamming SECDED decoder on a valid/ready stream with saturating error counters.
// Stage 1 computes syndrome and overall parity; stage 2 corrects, classifies and holds the result.
module hamming_secded_stream_decoder #(
  parameter  int DATA_W = 4,
  parameter  int CNT_W  = 16,
  // Smallest R with 2**R >= DATA_W + R + 1
  localparam int R      = (DATA_W <= 1)   ? 2 :
                          (DATA_W <= 4)   ? 3 :
                          (DATA_W <= 11)  ? 4 :
                          (DATA_W <= 26)  ? 5 :
                          (DATA_W <= 57)  ? 6 :
                          (DATA_W <= 120) ? 7 :
                          (DATA_W <= 247) ? 8 : 9,
  localparam int CW_W   = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [R-1:0]      err_pos,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [R-1:0] calc_syndrome(input logic [CW_W-1:0] cw);
    logic [R-1:0] s;
    s = '0;
    for (int p = 1; p < CW_W; p++) begin
      for (int k = 0; k < R; k++) begin
        if (((p >> k) & 1) != 0) s[k] = s[k] ^ cw[p-1];
      end
    end
    return s;
  endfunction

  // Data bits live at the non-power-of-two positions, lowest data bit first
  function automatic logic [DATA_W-1:0] extract_data(input logic [CW_W-1:0] cw);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int p = 1; p < CW_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[j] = cw[p-1];
        j++;
      end
    end
    return d;
  endfunction

  logic            s1_valid;
  logic [CW_W-1:0] s1_cw;
  logic [R-1:0]    s1_syn;
  logic            s1_par;

  logic            out_adv;
  logic            out_fire;
  logic [CW_W-1:0] corrected;
  logic            n_corr;
  logic            n_uncorr;

  assign out_adv  = !out_valid || out_ready;
  assign in_ready = !s1_valid || out_adv;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
      s1_par   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= codeword;
        s1_syn <= calc_syndrome(codeword);
        s1_par <= ^codeword;
      end
    end
  end

  // A nonzero syndrome beyond the last real position can only come from a multi-bit error
  always_comb begin
    corrected = s1_cw;
    n_corr    = 1'b0;
    n_uncorr  = 1'b0;
    if (s1_syn != '0) begin
      if (s1_par && (int'(s1_syn) <= CW_W - 1)) begin
        n_corr = 1'b1;
        for (int i = 0; i < CW_W - 1; i++) begin
          if (int'(s1_syn) == i + 1) corrected[i] = ~corrected[i];
        end
      end else begin
        n_uncorr = 1'b1;
      end
    end else if (s1_par) begin
      n_corr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      err_corr   <= 1'b0;
      err_uncorr <= 1'b0;
      err_pos    <= '0;
    end else if (out_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out   <= extract_data(corrected);
        err_corr   <= n_corr;
        err_uncorr <= n_uncorr;
        err_pos    <= s1_syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
    end else if (out_fire) begin
      if (err_corr && (corr_cnt != CNT_MAX))     corr_cnt   <= corr_cnt + CNT_W'(1);
      if (err_uncorr && (uncorr_cnt != CNT_MAX)) uncorr_cnt <= uncorr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hamming_secded_stream_decoder.sv
// Self-checking bench: encodes random data, injects 0/1/2 bit errors and compares the
// decoder stream against an in-order scoreboard and a saturating counter model.
module tb_hamming_secded_stream_decoder;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;
  localparam int R      = 3;
  localparam int CW_W   = 8;
  localparam int CMAX   = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW_W-1:0]   codeword = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] data_out;
  logic              err_corr;
  logic              err_uncorr;
  logic [R-1:0]      err_pos;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  corr_cnt;
  logic [CNT_W-1:0]  uncorr_cnt;

  hamming_secded_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codeword(codeword), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .err_corr(err_corr), .err_uncorr(err_uncorr),
    .err_pos(err_pos), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] data;
    logic       corr;
    logic       uncorr;
    logic [2:0] pos;
    int         entry;
  } exp_t;

  exp_t sb[$];
  int   edge_cnt   = 0;
  int   corr_m     = 0;
  int   uncorr_m   = 0;
  int   vectors    = 0;
  int   miscompares = 0;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    int         dpos[4];
    logic       par;
    dpos = '{3, 5, 6, 7};
    c = '0;
    for (int i = 0; i < 4; i++) c[dpos[i]-1] = d[i];
    for (int k = 0; k < 3; k++) begin
      par = 1'b0;
      for (int p = 1; p < 8; p++) if (((p >> k) & 1) != 0) par = par ^ c[p-1];
      c[(1 << k) - 1] = par;
    end
    c[7] = ^c[6:0];
    return c;
  endfunction

  // Expected outcome from the injected flip mask; the overall-parity bit counts as position 0
  function automatic exp_t expect_word(input logic [3:0] d, input logic [7:0] mask);
    exp_t       e;
    logic [7:0] cw;
    int         pos_x;
    cw    = encode(d) ^ mask;
    pos_x = 0;
    for (int b = 0; b < 7; b++) if (mask[b]) pos_x = pos_x ^ (b + 1);
    e = '0;
    e.data = d;
    e.pos  = 3'(pos_x);
    if ($countones(mask) == 1) begin
      e.corr = 1'b1;
    end else if ($countones(mask) == 2) begin
      e.uncorr = 1'b1;
      e.data   = {cw[6], cw[5], cw[4], cw[2]};
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(output logic exp_ov, output logic exp_ir);
    int n;
    n      = sb.size();
    exp_ov = (n > 0) && (edge_cnt >= sb[0].entry + 1);
    exp_ir = !((n == 2) && !out_ready);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("data_out", 32'(data_out), 32'(sb[0].data));
      chk("err_corr", 32'(err_corr), 32'(sb[0].corr));
      chk("err_uncorr", 32'(err_uncorr), 32'(sb[0].uncorr));
      chk("err_pos", 32'(err_pos), 32'(sb[0].pos));
    end
    chk("corr_cnt", 32'(corr_cnt), 32'(corr_m));
    chk("uncorr_cnt", 32'(uncorr_cnt), 32'(uncorr_m));
  endtask

  // One clock: drive at negedge, check, then advance the model across the rising edge
  task automatic applyStimulus(input logic iv, input logic [7:0] cw, input logic orr,
                               input logic clr, input exp_t e, output logic accepted);
    logic ov, ir;
    exp_t f;
    @(negedge clk);
    in_valid  = iv;
    codeword  = cw;
    out_ready = orr;
    cnt_clr   = clr;
    #1;
    checkOutput(ov, ir);
    @(posedge clk);
    edge_cnt++;
    if (ov && orr) begin
      f = sb.pop_front();
      if (!clr) begin
        if (f.corr && corr_m < CMAX) corr_m++;
        if (f.uncorr && uncorr_m < CMAX) uncorr_m++;
      end
    end
    if (clr) begin
      corr_m   = 0;
      uncorr_m = 0;
    end
    accepted = iv && ir;
    if (accepted) begin
      e.entry = edge_cnt;
      sb.push_back(e);
    end
  endtask

  task automatic sendWord(input logic [3:0] d, input logic [7:0] mask, input logic orr,
                          input logic clr);
    exp_t e;
    logic acc;
    e = expect_word(d, mask);
    applyStimulus(1'b1, encode(d) ^ mask, orr, clr, e, acc);
    for (int t = 0; t < 20 && !acc; t++) applyStimulus(1'b1, encode(d) ^ mask, 1'b1, 1'b0, e, acc);
    if (!acc) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL accept_timeout observed=in_ready_low expected=accept");
    end
  endtask

  task automatic idle(input logic orr, input logic clr, input int n);
    logic acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, orr, clr, '0, acc);
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() != 0; t++) idle(1'b1, 1'b0, 1);
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout observed=%0d_pending expected=0", sb.size());
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    edge_cnt += 2;
    sb.delete();
    corr_m   = 0;
    uncorr_m = 0;
    #1;
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_err_corr", 32'(err_corr), 32'd0);
    chk("rst_err_uncorr", 32'(err_uncorr), 32'd0);
    chk("rst_err_pos", 32'(err_pos), 32'd0);
    chk("rst_corr_cnt", 32'(corr_cnt), 32'd0);
    chk("rst_uncorr_cnt", 32'(uncorr_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] d;
    logic [7:0] m;
    int         b0, b1;

    doReset();

    $display("[TB] directed vectors");
    sendWord(4'hB, 8'h00, 1'b1, 1'b0);
    sendWord(4'hB, 8'h10, 1'b1, 1'b0);
    sendWord(4'hB, 8'h80, 1'b1, 1'b0);
    sendWord(4'hB, 8'h03, 1'b1, 1'b0);
    drain();
    chk("codeword_B", 32'(encode(4'hB)), 32'h55);

    $display("[TB] back-to-back with backpressure");
    sendWord(4'h1, 8'h00, 1'b1, 1'b0);
    sendWord(4'h7, 8'h04, 1'b0, 1'b0);
    sendWord(4'hC, 8'h21, 1'b1, 1'b0);
    sendWord(4'h9, 8'h40, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 2);
    drain();

    $display("[TB] counter saturation and clear");
    for (int i = 0; i < 5; i++) sendWord(4'(i), 8'h01, 1'b1, 1'b0);
    drain();
    chk("corr_cnt_sat", 32'(corr_cnt), 32'd3);
    sendWord(4'h5, 8'h08, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 1);
    idle(1'b1, 1'b1, 1);
    idle(1'b1, 1'b0, 1);
    chk("corr_cnt_clr", 32'(corr_cnt), 32'd0);

    $display("[TB] reset mid-stream");
    sendWord(4'h3, 8'h02, 1'b1, 1'b0);
    idle(1'b1, 1'b0, 2);
    sendWord(4'hA, 8'h00, 1'b0, 1'b0);
    sendWord(4'h6, 8'h00, 1'b0, 1'b0);
    doReset();

    $display("[TB] random stream");
    for (int w = 0; w < 200; w++) begin
      d  = 4'($urandom);
      m  = 8'h00;
      b0 = int'($urandom_range(0, 7));
      b1 = (b0 + int'($urandom_range(1, 7))) % 8;
      case ($urandom % 4)
        1: m[b0] = 1'b1;
        2: begin m[b0] = 1'b1; m[b1] = 1'b1; end
        default: m = 8'h00;
      endcase
      sendWord(d, m, ($urandom % 4) != 0, ($urandom % 16) == 0);
      if (($urandom % 5) == 0) idle(($urandom % 2) == 0, 1'b0, 1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
